// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - three-source priority arbiter feeding a seven-segment display
// Owner holds the display for HOLD_CYCLES unless a strictly higher-priority source preempts.
module seg_display_arbiter #(
  parameter int HOLD_CYCLES = 10000000,
  parameter int PAGE_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic        page_auto,
  input  logic        usr_btn,
  output logic [2:0]  ack,
  output logic [31:0] disp_number,
  output logic        disp_sel,
  output logic        disp_btn,
  output logic [1:0]  owner,
  output logic        busy
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int PW = $clog2(PAGE_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] PAGE_MAX = PW'(PAGE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHOW} state_t;

  state_t        state;
  logic [1:0]    winner;
  logic [HW-1:0] hold_cnt;
  logic [PW-1:0] page_cnt;
  logic          usr_q;
  logic [1:0]    top_idx;

  always_comb begin
    top_idx = 2'd0;
    if (req[2])      top_idx = 2'd2;
    else if (req[1]) top_idx = 2'd1;
  end

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    onehot = 3'b001 << idx;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      winner      <= 2'd0;
      ack         <= 3'b000;
      disp_number <= 32'h0;
      disp_sel    <= 1'b0;
      disp_btn    <= 1'b0;
      owner       <= 2'd3;
      busy        <= 1'b0;
      hold_cnt    <= '0;
      page_cnt    <= '0;
      usr_q       <= 1'b0;
    end else begin
      ack      <= 3'b000;
      disp_sel <= 1'b0;
      usr_q    <= usr_btn;
      case (state)
        IDLE: begin
          if (|req) begin
            winner <= top_idx;
            ack    <= onehot(top_idx);
            state  <= LOAD;
          end
        end
        LOAD: begin
          case (winner)
            2'd2:    disp_number <= data2;
            2'd1:    disp_number <= data1;
            default: disp_number <= data0;
          endcase
          owner    <= winner;
          disp_sel <= 1'b1;
          disp_btn <= 1'b0;
          page_cnt <= '0;
          hold_cnt <= '0;
          busy     <= 1'b1;
          state    <= SHOW;
        end
        SHOW: begin
          if (busy) begin
            if (hold_cnt == HOLD_MAX) busy <= 1'b0;
            else                      hold_cnt <= hold_cnt + HW'(1);
          end
          // A pending load suppresses any page or manual half change this cycle.
          if ((|req) && (!busy || (top_idx > owner))) begin
            winner <= top_idx;
            ack    <= onehot(top_idx);
            state  <= LOAD;
          end else if (page_auto) begin
            if (page_cnt == PAGE_MAX) begin
              page_cnt <= '0;
              if (|disp_number[31:16]) begin
                disp_btn <= ~disp_btn;
                disp_sel <= 1'b1;
              end else begin
                disp_btn <= 1'b0;
                disp_sel <= disp_btn;
              end
            end else begin
              page_cnt <= page_cnt + PW'(1);
            end
          end else if (usr_q != disp_btn) begin
            disp_btn <= usr_q;
            disp_sel <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb/tb_seg_display_arbiter.sv - directed self-checking bench for seg_display_arbiter
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_seg_display_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [31:0] data0, data1, data2;
  logic        page_auto, usr_btn;
  logic [2:0]  ack;
  logic [31:0] disp_number;
  logic        disp_sel, disp_btn;
  logic [1:0]  owner;
  logic        busy;

  int checks = 0;
  int failures = 0;

  seg_display_arbiter #(.HOLD_CYCLES(8), .PAGE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .req(req),
    .data0(data0), .data1(data1), .data2(data2),
    .page_auto(page_auto), .usr_btn(usr_btn),
    .ack(ack), .disp_number(disp_number), .disp_sel(disp_sel),
    .disp_btn(disp_btn), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"},   32'(ack), 32'd0);
    chk({tag, "_num"},   disp_number, 32'd0);
    chk({tag, "_sel"},   32'(disp_sel), 32'd0);
    chk({tag, "_btn"},   32'(disp_btn), 32'd0);
    chk({tag, "_owner"}, 32'(owner), 32'd3);
    chk({tag, "_busy"},  32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req = 3'b000; data0 = 32'h0; data1 = 32'h0; data2 = 32'h0;
    page_auto = 1'b0; usr_btn = 1'b0;
    tick(); tick();
    chk_reset_vals("por");
    reset = 1'b1;
    tick();
    chk("idle_ack", 32'(ack), 32'd0);

    // Source 0 takes an idle display.
    req = 3'b001; data0 = 32'h0000_1234;
    tick();
    chk("s0_ack", 32'(ack), 32'b001);
    chk("s0_num_before", disp_number, 32'h0);
    req = 3'b000;
    tick();
    chk("s0_num", disp_number, 32'h0000_1234);
    chk("s0_owner", 32'(owner), 32'd0);
    chk("s0_sel", 32'(disp_sel), 32'd1);
    chk("s0_busy", 32'(busy), 32'd1);
    chk("s0_ack_off", 32'(ack), 32'd0);
    tick();
    chk("s0_sel_off", 32'(disp_sel), 32'd0);

    // Source 2 preempts while source 0 is busy.
    req = 3'b100; data2 = 32'h0000_EEEE;
    tick();
    chk("pre_ack", 32'(ack), 32'b100);
    req = 3'b000;
    tick();
    chk("pre_num", disp_number, 32'h0000_EEEE);
    chk("pre_owner", 32'(owner), 32'd2);
    chk("pre_busy", 32'(busy), 32'd1);

    // Source 1 must wait for the hold window of source 2 to close.
    req = 3'b010; data1 = 32'h0000_1111;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("wait_ack_%0d", i), 32'(ack), 32'd0);
      chk($sformatf("wait_busy_%0d", i), 32'(busy), (i < 8) ? 32'd1 : 32'd0);
      chk($sformatf("wait_sel_%0d", i), 32'(disp_sel), 32'd0);
    end
    tick();
    chk("s1_ack", 32'(ack), 32'b010);
    req = 3'b000;
    tick();
    chk("s1_owner", 32'(owner), 32'd1);
    chk("s1_num", disp_number, 32'h0000_1111);
    chk("s1_busy0", 32'(busy), 32'd1);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("hold_busy_%0d", i), 32'(busy), 32'd1);
    end
    tick();
    chk("hold_busy_end", 32'(busy), 32'd0);

    // Manual half select follows usr_btn one registered cycle late.
    usr_btn = 1'b1;
    tick();
    chk("man_btn_lag", 32'(disp_btn), 32'd0);
    tick();
    chk("man_btn_up", 32'(disp_btn), 32'd1);
    chk("man_sel_up", 32'(disp_sel), 32'd1);
    tick();
    chk("man_sel_off", 32'(disp_sel), 32'd0);
    usr_btn = 1'b0;
    tick(); tick();
    chk("man_btn_dn", 32'(disp_btn), 32'd0);
    chk("man_sel_dn", 32'(disp_sel), 32'd1);

    // Auto paging with a nonzero upper half.
    page_auto = 1'b1; req = 3'b001; data0 = 32'hABCD_0012;
    tick();
    chk("pg_ack", 32'(ack), 32'b001);
    req = 3'b000;
    tick();
    chk("pg_num", disp_number, 32'hABCD_0012);
    chk("pg_btn0", 32'(disp_btn), 32'd0);
    chk("pg_sel0", 32'(disp_sel), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("pg_btn_%0d", i), 32'(disp_btn), (i >= 4 && i < 8) ? 32'd1 : 32'd0);
      chk($sformatf("pg_sel_%0d", i), 32'(disp_sel), (i == 4 || i == 8) ? 32'd1 : 32'd0);
    end

    // Auto paging with a zero upper half never toggles.
    req = 3'b001; data0 = 32'h0000_0012;
    tick();
    chk("pz_ack", 32'(ack), 32'b001);
    req = 3'b000;
    tick();
    chk("pz_num", disp_number, 32'h0000_0012);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("pz_btn_%0d", i), 32'(disp_btn), 32'd0);
      chk($sformatf("pz_sel_%0d", i), 32'(disp_sel), 32'd0);
    end

    // Back to idle, then all three request at once.
    reset = 1'b0;
    tick();
    chk_reset_vals("rst2");
    reset = 1'b1;
    req = 3'b111; data1 = 32'h1111_1111; data2 = 32'h2222_2222;
    tick();
    chk("all_ack", 32'(ack), 32'b100);
    req = 3'b011;
    tick();
    chk("all_owner", 32'(owner), 32'd2);
    chk("all_num", disp_number, 32'h2222_2222);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("all_wait_ack_%0d", i), 32'(ack), 32'd0);
    end
    tick();
    chk("all_s1_ack", 32'(ack), 32'b010);

    // Reset while in LOAD aborts immediately.
    req = 3'b000;
    reset = 1'b0;
    #1;
    chk_reset_vals("abort");
    tick();
    reset = 1'b1;
    tick(); tick();
    chk("post_ack", 32'(ack), 32'd0);
    chk("post_owner", 32'(owner), 32'd3);
    chk("post_num", disp_number, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 10000000, minimum ownership time in clk cycles before an equal-or-lower-priority source may take the display.
REQ-002 Parameter PAGE_CYCLES, default 50000000, auto page-flip period in clk cycles.
REQ-003 clk  input  1  single clock; all state on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  3  request per source; bit2 error/status, bit1 result, bit0 key entry.
REQ-006 data0, data1, data2  input  32 each  value offered by source 0/1/2.
REQ-007 ack  output  3  one-hot, one-cycle grant/capture pulse per source.
REQ-008 page_auto  input  1  1 = automatic half-page flipping; 0 = manual.
REQ-009 usr_btn  input  1  manual half select (1 = upper 16 bits), used when page_auto=0.
REQ-010 disp_number  output  32  value driven to the seven-segment display.
REQ-011 disp_sel  output  1  one-cycle load strobe to the display.
REQ-012 disp_btn  output  1  half select to the display (1 = [31:16]).
REQ-013 owner  output  2  index of current owning source; 3 = none.
REQ-014 busy  output  1  high while the hold window is running.

Function
REQ-015 FSM states IDLE, LOAD, SHOW; reset enters IDLE.
REQ-016 Priority: source 2 > source 1 > source 0; ties are resolved by priority only.
REQ-017 IDLE: any req bit set -> latch winner, go to LOAD next cycle; else stay.
REQ-018 LOAD lasts exactly one cycle: ack[winner]=1, data of winner captured into disp_number at the end of the cycle, owner<=winner, go to SHOW.
REQ-019 Latency: req sampled high at edge N (IDLE) -> ack high in cycle N..N+1 -> disp_number and owner updated and disp_sel=1 in cycle after LOAD.
REQ-020 The req protocol holds req until ack; if req drops during LOAD, ack still pulses and data is still captured.
REQ-021 On entering SHOW from LOAD, the hold counter clears to 0 and busy=1; the counter increments each SHOW cycle and busy drops when it reaches HOLD_CYCLES-1, then saturates.
REQ-022 SHOW, busy=1: a request from a source of strictly higher priority than owner preempts -> LOAD next cycle; other requests wait (no ack).
REQ-023 SHOW, busy=0: any request (including the owner's) -> highest-priority pending wins -> LOAD next cycle.
REQ-024 SHOW with no qualifying request: remain in SHOW, disp_number held indefinitely.
REQ-025 Page, page_auto=1: page counter counts in SHOW and wraps at PAGE_CYCLES-1; on wrap, disp_btn toggles only if disp_number[31:16]!=0, else disp_btn forced 0.
REQ-026 Page, page_auto=0: disp_btn follows registered usr_btn with one-cycle delay.
REQ-027 Every change of disp_btn is accompanied by disp_sel=1 in the same cycle.
REQ-028 Every load forces disp_btn=0 and clears the page counter; a load coinciding with a page wrap or usr_btn change takes precedence.
REQ-029 disp_sel is never high two consecutive cycles except a load strobe followed by a manual-toggle strobe.
REQ-030 ack is never multi-hot; at most one LOAD per two cycles.

Reset
REQ-031 reset low asynchronously forces: state IDLE, ack=0, disp_number=0, disp_sel=0, disp_btn=0, owner=3, busy=0, counters=0.
REQ-032 Reset asserted mid-LOAD or mid-SHOW aborts with no ack pulse after assertion; after release the block behaves as from power-up.

Verification (HOLD_CYCLES=8, PAGE_CYCLES=4)
REQ-033 Release reset, req=3'b001, data0=32'h0000_1234 -> ack=001 one cycle, then disp_number=0000_1234, owner=0, disp_sel pulse, busy high 8 cycles.
REQ-034 While owner=0 busy, req=3'b100, data2=32'h0000_EEEE -> preempt: ack=100, disp_number=0000_EEEE, owner=2.
REQ-035 While owner=2 busy, req=3'b010 -> no ack until busy drops, then ack=010 and owner=1.
REQ-036 page_auto=1, load 32'hABCD_0012 -> disp_btn toggles 0->1->0 every 4 cycles, each with disp_sel; load 32'h0000_0012 -> disp_btn stays 0.
REQ-037 req=3'b111 in IDLE -> only ack=100; after hold expires with req=011 still high -> ack=010.
REQ-038 reset pulsed low during LOAD -> ack drops immediately, all outputs at REQ-031 values, owner=3.
